// File: rtl/dpram_fifo_ctrl_pkg.sv
// Shared constants for the dual-port-RAM FIFO controller.
// Output-stage occupancy encodings used by the controller and its output stage.
package dpram_fifo_ctrl_pkg;

    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE   = 2'd1;
    localparam logic [1:0] OCC_FULL  = 2'd2;

endpackage

// File: rtl/dpram_fifo_ostage.sv
// Two-entry output stage (output register plus skid) that absorbs RAM read
// latency so the FIFO can pop one word per cycle.
module dpram_fifo_ostage
    import dpram_fifo_ctrl_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cap_valid,
    input  logic [WIDTH-1:0] cap_data,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occ
);

    logic [1:0]       occ_q;
    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] skid_q;
    logic             pop;
    logic             cap_to_out;

    assign out_valid = (occ_q != OCC_EMPTY);
    assign out_data  = out_q;
    assign occ       = occ_q;
    assign pop       = out_valid && out_ready;

    // A capture bypasses the skid when the output register is (or is becoming) free;
    // the issue rule guarantees no capture ever arrives while occ is already full.
    assign cap_to_out = cap_valid && ((occ_q == OCC_EMPTY) || (pop && occ_q == OCC_ONE));

    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q <= OCC_EMPTY;
            out_q <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            occ_q <= occ_q + {1'b0, cap_valid} - {1'b0, pop};
            if (cap_to_out)
                out_q <= cap_data;
            else if (pop && occ_q == OCC_FULL)
                out_q <= skid_q;
        end
    end

    // NOTE: the skid holds data only while occ says so, so it needs no reset.
    always_ff @(posedge clk) begin
        if (cap_valid && !cap_to_out)
            skid_q <= cap_data;
    end

endmodule

// File: rtl/dpram_fifo_ctrl.sv
// FIFO controller owning both ports of an external true dual-port RAM:
// port A writes pushes, port B prefetches into a 2-entry output stage.
module dpram_fifo_ctrl
    import dpram_fifo_ctrl_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int LOCATION = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [WIDTH-1:0]              in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [WIDTH-1:0]              out_data,
    output logic [$clog2(LOCATION):0]     count,
    output logic                          ram_we_a,
    output logic [$clog2(LOCATION)-1:0]   ram_addr_a,
    output logic [WIDTH-1:0]              ram_din_a,
    output logic                          ram_we_b,
    output logic [$clog2(LOCATION)-1:0]   ram_addr_b,
    input  logic [WIDTH-1:0]              ram_dout_b
);

    localparam int AW = $clog2(LOCATION);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   mem_cnt;
    logic          pending;
    logic [1:0]    occ;
    logic          push;
    logic          pop;
    logic          issue;

    assign in_ready = !rst && (mem_cnt != (AW+1)'(LOCATION));
    assign push     = in_valid && in_ready;
    assign pop      = out_valid && out_ready;

    // Fetch only if the word will find a free output-stage slot when it lands;
    // mem_cnt excludes this cycle's push, so a fresh word is never read same-cycle.
    assign issue = (mem_cnt != '0) &&
                   (({1'b0, occ} + {2'b0, pending}) < (3'd2 + {2'b0, pop}));

    assign ram_we_a   = push;
    assign ram_addr_a = wr_ptr;
    assign ram_din_a  = in_data;
    assign ram_we_b   = 1'b0;
    assign ram_addr_b = rd_ptr;

    assign count = mem_cnt + (AW+1)'(pending) + (AW+1)'(occ);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            mem_cnt <= '0;
            pending <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (issue)
                rd_ptr <= rd_ptr + AW'(1);
            mem_cnt <= mem_cnt + (AW+1)'(push) - (AW+1)'(issue);
            pending <= issue;
        end
    end

    dpram_fifo_ostage #(
        .WIDTH(WIDTH)
    ) u_ostage (
        .clk       (clk),
        .rst       (rst),
        .cap_valid (pending),
        .cap_data  (ram_dout_b),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .occ       (occ)
    );

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// Directed bench for dpram_fifo_ctrl with a behavioural registered-read
// dual-port RAM beside it, as in the parent design.
module tb_dpram_fifo_ctrl;

    localparam int WIDTH    = 4;
    localparam int LOCATION = 16;
    localparam int AW       = $clog2(LOCATION);

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [AW:0]      count;
    logic             ram_we_a;
    logic [AW-1:0]    ram_addr_a;
    logic [WIDTH-1:0] ram_din_a;
    logic             ram_we_b;
    logic [AW-1:0]    ram_addr_b;
    logic [WIDTH-1:0] ram_dout_b;

    int checks = 0;
    int errors = 0;

    dpram_fifo_ctrl #(
        .WIDTH(WIDTH),
        .LOCATION(LOCATION)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .count      (count),
        .ram_we_a   (ram_we_a),
        .ram_addr_a (ram_addr_a),
        .ram_din_a  (ram_din_a),
        .ram_we_b   (ram_we_b),
        .ram_addr_b (ram_addr_b),
        .ram_dout_b (ram_dout_b)
    );

    // Registered-read RAM; a same-cycle write and read of one address returns old data.
    logic [WIDTH-1:0] ram [LOCATION];
    always_ff @(posedge clk) begin
        if (ram_we_a)
            ram[ram_addr_a] <= ram_din_a;
        ram_dout_b <= ram[ram_addr_b];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle; inputs are driven at edge+1, outputs sampled at edge+2.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        rst = 1'b1;
        cyc();
        cyc();
        in_valid = 1'b1; in_data = 4'h7;
        settle();
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        checks++;
        if (ram_we_a !== 1'b0) begin errors++; $display("FAIL reset_we_a: got %b want 0", ram_we_a); end
        checks++;
        if (out_valid !== 1'b0 || count !== 5'd0) begin
            errors++; $display("FAIL reset_state: out_valid=%b count=%0d want 0/0", out_valid, count);
        end
        checks++;
        if (out_data !== 4'h0) begin errors++; $display("FAIL reset_out_data: got %h want 0", out_data); end
        checks++;
        if (ram_we_b !== 1'b0) begin errors++; $display("FAIL reset_we_b: got %b want 0", ram_we_b); end
        in_valid = 1'b0;
        cyc();
        rst = 1'b0;
        settle();
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_single();
        do_reset();
        in_valid = 1'b1; in_data = 4'hA; out_ready = 1'b1;
        settle();
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL single_in_ready: got %b want 1", in_ready); end
        for (int c = 1; c <= 4; c++) begin
            cyc();
            in_valid = 1'b0;
            settle();
            checks++;
            if (c < 3 && (out_valid !== 1'b0 || count !== 5'd1)) begin
                errors++; $display("FAIL single_c%0d: out_valid=%b count=%0d want 0/1", c, out_valid, count);
            end else if (c == 3 && (out_valid !== 1'b1 || out_data !== 4'hA || count !== 5'd1)) begin
                errors++; $display("FAIL single_c3: out_valid=%b data=%h count=%0d want 1/a/1", out_valid, out_data, count);
            end else if (c == 4 && (out_valid !== 1'b0 || count !== 5'd0 || out_data !== 4'hA)) begin
                errors++; $display("FAIL single_c4: out_valid=%b count=%0d data=%h want 0/0/a", out_valid, count, out_data);
            end
        end
    endtask

    task automatic test_fill();
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1; in_data = WIDTH'(i);
            settle();
            checks++;
            if (in_ready !== (i < 18)) begin
                errors++; $display("FAIL fill_in_ready_%0d: got %b want %b", i, in_ready, (i < 18));
            end
            cyc();
        end
        in_valid = 1'b0;
        cyc();
        cyc();
        settle();
        checks++;
        if (count !== 5'd18 || out_valid !== 1'b1 || out_data !== 4'h0) begin
            errors++; $display("FAIL fill_state: count=%0d valid=%b data=%h want 18/1/0", count, out_valid, out_data);
        end
    endtask

    task automatic test_drain();
        out_ready = 1'b1; in_valid = 1'b0;
        for (int i = 0; i < 18; i++) begin
            settle();
            checks++;
            if (out_valid !== 1'b1 || out_data !== WIDTH'(i)) begin
                errors++; $display("FAIL drain_%0d: valid=%b data=%h want 1/%h", i, out_valid, out_data, WIDTH'(i));
            end
            cyc();
        end
        settle();
        checks++;
        if (out_valid !== 1'b0 || count !== 5'd0) begin
            errors++; $display("FAIL drain_end: valid=%b count=%0d want 0/0", out_valid, count);
        end
    endtask

    task automatic test_streaming();
        out_ready = 1'b1;
        for (int t = 0; t < 44; t++) begin
            in_valid = (t < 40);
            in_data  = WIDTH'(t);
            settle();
            if (t < 40) begin
                checks++;
                if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready_%0d: got %b want 1", t, in_ready); end
            end
            checks++;
            if (t >= 3 && t < 43) begin
                if (out_valid !== 1'b1 || out_data !== WIDTH'(t - 3)) begin
                    errors++; $display("FAIL stream_out_%0d: valid=%b data=%h want 1/%h", t, out_valid, out_data, WIDTH'(t - 3));
                end
            end else if (out_valid !== 1'b0) begin
                errors++; $display("FAIL stream_idle_%0d: valid=%b want 0", t, out_valid);
            end
            cyc();
        end
        in_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [WIDTH-1:0] sb[$];
        int pushed = 0;
        int budget = 0;
        bit do_push;
        bit do_pop;
        logic [WIDTH-1:0] exp;
        do_reset();
        while ((pushed < 200 || sb.size() != 0) && budget < 5000) begin
            in_valid  = (pushed < 200) && ($urandom_range(0, 3) != 0);
            in_data   = WIDTH'($urandom);
            out_ready = ($urandom_range(0, 1) == 1) || (pushed >= 200);
            settle();
            checks++;
            if (count !== (AW+1)'(sb.size()) || count > 5'd18) begin
                errors++; $display("FAIL bp_count: got %0d want %0d", count, sb.size());
            end
            do_push = in_valid && in_ready;
            do_pop  = out_valid && out_ready;
            if (do_pop) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++; $display("FAIL bp_spurious: got data %h want no output", out_data);
                end else begin
                    exp = sb.pop_front();
                    if (out_data !== exp) begin
                        errors++; $display("FAIL bp_order: got %h want %h", out_data, exp);
                    end
                end
            end
            if (do_push) begin
                sb.push_back(in_data);
                pushed++;
            end
            cyc();
            budget++;
        end
        checks++;
        if (budget >= 5000) begin
            errors++; $display("FAIL bp_timeout: pushed %0d outstanding %0d want 200/0", pushed, sb.size());
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset_midop();
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; in_data = WIDTH'(i + 3);
            cyc();
        end
        in_valid = 1'b0;
        settle();
        checks++;
        if (count !== 5'd10) begin errors++; $display("FAIL midop_held: got %0d want 10", count); end
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        in_valid = 1'b1; in_data = 4'h5; out_ready = 1'b1;
        settle();
        checks++;
        if (out_valid !== 1'b0 || count !== 5'd0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL midop_after_rst: valid=%b count=%0d ready=%b want 0/0/1", out_valid, count, in_ready);
        end
        for (int c = 1; c <= 4; c++) begin
            cyc();
            in_valid = 1'b0;
            settle();
            checks++;
            if (c == 3) begin
                if (out_valid !== 1'b1 || out_data !== 4'h5 || count !== 5'd1) begin
                    errors++; $display("FAIL midop_c3: valid=%b data=%h count=%0d want 1/5/1", out_valid, out_data, count);
                end
            end else if (out_valid !== 1'b0) begin
                errors++; $display("FAIL midop_c%0d: valid=%b want 0", c, out_valid);
            end
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        test_reset();
        test_single();
        test_fill();
        test_drain();
        test_streaming();
        test_backpressure();
        test_reset_midop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dpram_fifo_ctrl.md
Name: dpram_fifo_ctrl

Overview:
- Synchronous FIFO controller that sits directly upstream of the team's true dual-port RAM and owns both of its ports.
- Port A is write-only and port B is read-only.
- Provides valid/ready push and pop interfaces and hides the RAM's 1-cycle registered read latency behind a 2-entry output stage (output register plus skid), so sustained throughput is 1 word/cycle.
- Used wherever a block needs buffered streaming through the existing dual-port RAM.

Parameters:
- WIDTH, 4, data word width; must match RAM WIDTH.
- LOCATION, 16, RAM depth; power of 2, ≥2; must match RAM LOCATION.
- AW (localparam), $clog2(LOCATION), RAM address width.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  push request
- in_ready  output  1  push accepted when in_valid&&in_ready
- in_data  input  WIDTH  push data
- out_valid  output  1  out_data valid
- out_ready  input  1  pop when out_valid&&out_ready
- out_data  output  WIDTH  head-of-FIFO data
- count  output  AW+1  total words held (RAM + in-flight + output stage), 0..LOCATION+2
- ram_we_a  output  1  to RAM we_a
- ram_addr_a  output  AW  to RAM addr_a
- ram_din_a  output  WIDTH  to RAM din_a
- ram_we_b  output  1  to RAM we_b; constant 0
- ram_addr_b  output  AW  to RAM addr_b
- ram_dout_b  input  WIDTH  from RAM dout_b; registered, valid the cycle after address presented with we_b=0

Behaviour:
- State: wr_ptr[AW-1:0], rd_ptr[AW-1:0], mem_cnt[AW:0] (words in RAM not yet fetched), pending (read issued last cycle), occ[1:0] (output stage entries, 0..2).
- Reset (rst high at edge):
  - ptrs=0, mem_cnt=0, pending=0, occ=0, out_data=0.
  - Outputs: out_valid=0, count=0.
  - While rst is high: in_ready=0 and ram_we_a=0.
  - Reset mid-operation discards all contents. RAM contents are not cleared, but are unreachable.
- Push:
  - in_ready = !rst && (mem_cnt != LOCATION), from registered state only.
  - push = in_valid&&in_ready.
  - ram_we_a=push, ram_addr_a=wr_ptr, ram_din_a=in_data, all combinational.
  - wr_ptr increments mod LOCATION on push.
- Issue (fetch):
  - ram_addr_b=rd_ptr at all times.
  - pop = out_valid&&out_ready.
  - issue = (mem_cnt!=0) && (occ + pending - pop < 2).
  - On issue: rd_ptr increments mod LOCATION and pending<=1; otherwise pending<=0.
  - mem_cnt <= mem_cnt + push - issue.
  - A word pushed in cycle c is not issuable before cycle c+1. This rules out a same-address read/write in one cycle, because the RAM returns old data in that case.
- Capture:
  - When pending=1, ram_dout_b is valid that cycle and is written into the output stage at the next edge.
  - If the output register is empty, or is being popped with the skid empty, the word goes to the output register; otherwise it goes to the skid.
  - On a pop with the skid full, skid moves to the output register.
  - Order is strictly FIFO.
- out_valid = (occ!=0); out_data = output register.
- count = mem_cnt + pending + occ, registered-consistent.
- Latency: into an empty FIFO, a push in cycle c gives out_valid in cycle c+3.
- Steady state: with in_valid=out_ready=1, one word per cycle in and out, no bubbles after fill.
- Full: mem_cnt==LOCATION gives in_ready=0. Max total held = LOCATION+2.
- Empty: out_valid=0 and out_data holds its last value (0 after reset).
- Simultaneous push and issue when mem_cnt==0: the push is stored and the issue is suppressed.
- Pointers wrap silently; capacity is tracked by mem_cnt, not by pointer compare.
- Push when in_ready=0 is ignored; in_data is not sampled.

Decomposition:
- Shared package: none required.
- AW is a localparam; occ encodings are plain 2-bit constants.
- One natural sub-module: dpram_fifo_ostage (2-entry output register/skid with occ tracking).
- The RAM stays external and is instantiated beside this controller in the parent.

Test Plan:
- Single word: after reset push 0xA in cycle 0, out_ready=1 -> out_valid=1, out_data=0xA in cycle 3, count 1→0 after pop.
- Fill: LOCATION=16, out_ready=0, push 0..19 continuously -> exactly 18 accepted, in_ready=0 from accept #18, count=18, pushes 18–19 dropped.
- Drain: continue from fill with out_ready=1 -> out_data 0..17 on consecutive cycles, then out_valid=0, count=0.
- Streaming: in_valid=out_ready=1 for 40 words with data=index -> outputs 0..39 in order, one per cycle after 3-cycle fill; addresses wrap twice with no loss.
- Backpressure: random out_ready (~50%) and in_valid for 200 words -> scoreboard exact order match, count never exceeds 18.
- Reset mid-op: 10 words held, assert rst for 1 cycle -> next cycle out_valid=0, count=0, in_ready=1; a subsequent push of 0x5 reappears alone at cycle +3.
